// File: rtl/tile_render_pkg.sv
// Shared types and constants for the tile frame renderer:
// FSM states, LCD opcodes and the RGB565 palette table.
package tile_render_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_SWRST,
        S_WAIT1,
        S_SLPOUT,
        S_WAIT2,
        S_COLMOD,
        S_DISPON,
        S_HDR,
        S_PIX,
        S_EOF
    } state_t;

    localparam logic [7:0] SWRESET    = 8'h01;
    localparam logic [7:0] SLPOUT     = 8'h11;
    localparam logic [7:0] COLMOD     = 8'h3A;
    localparam logic [7:0] COLMOD_565 = 8'h55;
    localparam logic [7:0] DISPON     = 8'h29;
    localparam logic [7:0] CASET      = 8'h2A;
    localparam logic [7:0] RASET      = 8'h2B;
    localparam logic [7:0] RAMWR      = 8'h2C;

    localparam int PAL_N = 2;
    localparam int CLS_N = 4;
    localparam int ENT_N = CLS_N + 2;

    // Entry order: background, head, body, apple, border, grid.
    localparam logic [15:0] PALETTE [PAL_N][ENT_N] = '{
        '{16'h0000, 16'h07E0, 16'h0400, 16'hFFE0, 16'h001F, 16'h8410},
        '{16'h2104, 16'hFD20, 16'hA145, 16'hF81F, 16'h7BEF, 16'hC618}
    };

    localparam logic [15:0] GAMEOVER_BG = 16'hF800;

endpackage

// File: rtl/tile_frame_renderer_lcd_byte_writer.sv
// Two-clock 8080 byte writer: cycle A drives D/dcx with wr=0,
// cycle B raises wr. Ports: clk, nrst, valid/ready, req_dcx,
// req_data in; dcx, wr, D out. ready is high in cycle B and idle.
module lcd_byte_writer (
    input  logic       clk,
    input  logic       nrst,
    input  logic       valid,
    output logic       ready,
    input  logic       req_dcx,
    input  logic [7:0] req_data,
    output logic       dcx,
    output logic       wr,
    output logic [7:0] D
);

    logic phase_a;

    assign ready = ~phase_a;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase_a <= 1'b0;
            wr      <= 1'b1;
            dcx     <= 1'b0;
            D       <= '0;
        end else if (phase_a) begin
            phase_a <= 1'b0;
            wr      <= 1'b1;
        end else if (valid) begin
            phase_a <= 1'b1;
            wr      <= 1'b0;
            dcx     <= req_dcx;
            D       <= req_data;
        end
    end

endmodule

// File: rtl/tile_frame_renderer.sv
// Tile map to RGB565 LCD renderer with init sequence, palettes,
// game-over tint and frame_done. Ports: clk, nrst, obj, KeyEnc,
// GameOver in; x, y, sync, dcx, wr, D, frame_done out.
// Optional macro GRID_LINES_EN draws tile grid lines.
module tile_frame_renderer
    import tile_render_pkg::*;
#(
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 12,
    parameter int TILE_PX      = 20,
    parameter int NUM_CLASSES  = CLS_N,
    parameter int NUM_PALETTES = PAL_N,
    parameter int INIT_WAIT    = 1200
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_CLASSES-1:0]    obj,
    input  logic                      KeyEnc,
    input  logic                      GameOver,
    output logic [$clog2(GRID_W)-1:0] x,
    output logic [$clog2(GRID_H)-1:0] y,
    output logic                      sync,
    output logic                      dcx,
    output logic                      wr,
    output logic [7:0]                D,
    output logic                      frame_done
);

    localparam int XW  = $clog2(GRID_W);
    localparam int YW  = $clog2(GRID_H);
    localparam int PCW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam int PW  = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
    localparam int EW  = $clog2(NUM_CLASSES + 2);
    localparam int WCW = $clog2(INIT_WAIT + 1);

    localparam logic [15:0]    FW       = 16'(GRID_W * TILE_PX - 1);
    localparam logic [15:0]    FH       = 16'(GRID_H * TILE_PX - 1);
    localparam logic [XW-1:0]  X_LAST   = XW'(GRID_W - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(GRID_H - 1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(TILE_PX - 1);
    localparam logic [PW-1:0]  PAL_LAST = PW'(NUM_PALETTES - 1);
    localparam logic [WCW-1:0] W_LAST   = WCW'(INIT_WAIT - 1);

    state_t         state;
    logic [3:0]     idx;
    logic           sent;
    logic [WCW-1:0] wcnt;
    logic           hb;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] pr;
    logic [XW-1:0]  tx;
    logic [YW-1:0]  ty;
    logic [15:0]    prow;
    logic [EW-1:0]  cls_q;
    logic [PW-1:0]  pal;
    logic           pend;
    logic           key_q;
    logic           go_q;

    logic           wr_ready;
    logic           req_valid;
    logic           req_dcx;
    logic [7:0]     req_data;
    logic           acc;
    logic           key_rise;
    logic [8:0]     hdr_byte;
    logic [EW-1:0]  obj_ent;
    logic [EW-1:0]  ent;
    logic           first;
    logic [15:0]    color;
    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;

    assign acc      = req_valid & wr_ready;
    assign key_rise = KeyEnc & ~key_q;
    assign first    = ~hb && (pc == '0);

    // First byte of a span takes the class straight from obj;
    // the rest of the span reuses the value captured then.
    assign ent = first ? obj_ent : cls_q;

    always_comb begin
        obj_ent = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (obj[i]) obj_ent = EW'(i + 1);
        end
    end

    always_comb begin
        color = PALETTE[pal][ent];
        if (ent == '0 && go_q) color = GAMEOVER_BG;
`ifdef GRID_LINES_EN
        if (pc == '0 || pr == '0)
            color = PALETTE[pal][EW'(NUM_CLASSES + 1)];
`endif
    end

    // Coordinates of the span that follows the current one.
    always_comb begin
        nx = (tx == X_LAST) ? '0 : tx + 1'b1;
        ny = ty;
        if (tx == X_LAST && pr == PC_LAST)
            ny = (ty == Y_LAST) ? '0 : ty + 1'b1;
    end

    always_comb begin
        unique case (idx)
            4'd0:    hdr_byte = {1'b0, CASET};
            4'd3:    hdr_byte = {1'b1, FW[15:8]};
            4'd4:    hdr_byte = {1'b1, FW[7:0]};
            4'd5:    hdr_byte = {1'b0, RASET};
            4'd8:    hdr_byte = {1'b1, FH[15:8]};
            4'd9:    hdr_byte = {1'b1, FH[7:0]};
            4'd10:   hdr_byte = {1'b0, RAMWR};
            default: hdr_byte = {1'b1, 8'h00};
        endcase
    end

    always_comb begin
        req_valid = 1'b0;
        req_dcx   = 1'b0;
        req_data  = '0;
        case (state)
            S_SWRST: begin
                req_valid = ~sent;
                req_data  = SWRESET;
            end
            S_SLPOUT: begin
                req_valid = ~sent;
                req_data  = SLPOUT;
            end
            S_COLMOD: begin
                req_valid = 1'b1;
                req_dcx   = idx[0];
                req_data  = idx[0] ? COLMOD_565 : COLMOD;
            end
            S_DISPON: begin
                req_valid = 1'b1;
                req_data  = DISPON;
            end
            S_HDR: begin
                req_valid = 1'b1;
                req_dcx   = hdr_byte[8];
                req_data  = hdr_byte[7:0];
            end
            S_PIX: begin
                req_valid = 1'b1;
                req_dcx   = 1'b1;
                req_data  = hb ? color[7:0] : color[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_BOOT;
            sync       <= 1'b1;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
            idx        <= '0;
            sent       <= 1'b0;
            wcnt       <= '0;
            hb         <= 1'b0;
            pc         <= '0;
            pr         <= '0;
            tx         <= '0;
            ty         <= '0;
            prow       <= '0;
            cls_q      <= '0;
            pal        <= '0;
            pend       <= 1'b0;
            key_q      <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            key_q      <= KeyEnc;
            if (key_rise) pend <= 1'b1;
            case (state)
                S_BOOT: begin
                    state <= S_SWRST;
                    sync  <= 1'b0;
                end
                // Hold chip select until the strobe has finished.
                S_SWRST, S_SLPOUT: begin
                    if (!sent) begin
                        if (acc) sent <= 1'b1;
                    end else if (wr_ready) begin
                        sent  <= 1'b0;
                        sync  <= 1'b1;
                        state <= (state == S_SWRST) ? S_WAIT1 : S_WAIT2;
                    end
                end
                S_WAIT1, S_WAIT2: begin
                    if (wcnt == W_LAST) begin
                        wcnt  <= '0;
                        sync  <= 1'b0;
                        state <= (state == S_WAIT1) ? S_SLPOUT : S_COLMOD;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_COLMOD: begin
                    if (acc) begin
                        if (idx == 4'd1) begin
                            idx   <= '0;
                            state <= S_DISPON;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DISPON: begin
                    if (acc) state <= S_HDR;
                end
                S_HDR: begin
                    go_q <= GameOver;
                    if (acc) begin
                        if (idx == 4'd10) begin
                            idx   <= '0;
                            state <= S_PIX;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_PIX: begin
                    if (acc) begin
                        hb <= ~hb;
                        if (first) cls_q <= obj_ent;
                        if (hb) begin
                            if (pc != PC_LAST) begin
                                pc <= pc + 1'b1;
                            end else begin
                                pc <= '0;
                                x  <= nx;
                                y  <= ny;
                                if (tx != X_LAST) begin
                                    tx <= tx + 1'b1;
                                end else begin
                                    tx <= '0;
                                    if (prow == FH) begin
                                        prow  <= '0;
                                        pr    <= '0;
                                        ty    <= '0;
                                        state <= S_EOF;
                                    end else begin
                                        prow <= prow + 1'b1;
                                        if (pr == PC_LAST) begin
                                            pr <= '0;
                                            ty <= ty + 1'b1;
                                        end else begin
                                            pr <= pr + 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                S_EOF: begin
                    if (wr_ready) begin
                        frame_done <= 1'b1;
                        state      <= S_HDR;
                        if (pend) begin
                            pal  <= (pal == PAL_LAST) ? '0 : pal + 1'b1;
                            pend <= key_rise;
                        end
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    lcd_byte_writer u_writer (
        .clk      (clk),
        .nrst     (nrst),
        .valid    (req_valid),
        .ready    (wr_ready),
        .req_dcx  (req_dcx),
        .req_data (req_data),
        .dcx      (dcx),
        .wr       (wr),
        .D        (D)
    );

endmodule
